// File: rtl/xy2_100_rx_if.sv
// XY2-100 receiver pin and result bundle.
// The master side drives the serial pins; the slave side is the receiver.
interface xy2_100_rx_if;
  logic        xy_sync;
  logic        xy_clk;
  logic        xy_x;
  logic        xy_y;
  logic [15:0] x_pos;
  logic [15:0] y_pos;
  logic        x_valid;
  logic        y_valid;
  logic        x_err;
  logic        y_err;
  logic [15:0] err_cnt;
  logic        link_ok;

  modport master (
    output xy_sync, xy_clk, xy_x, xy_y,
    input  x_pos, y_pos, x_valid, y_valid, x_err, y_err, err_cnt, link_ok
  );

  modport slave (
    input  xy_sync, xy_clk, xy_x, xy_y,
    output x_pos, y_pos, x_valid, y_valid, x_err, y_err, err_cnt, link_ok
  );
endinterface

// File: rtl/xy2_100_rx.sv
// XY2-100 galvo link receiver: decodes 20-bit X/Y frames into 16-bit setpoints
// and supervises link health with framing/parity checks and a watchdog.
module xy2_100_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 8200,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic         clk_in,
  input  logic         sys_rstn,
  xy2_100_rx_if.slave  bus
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  // All four pins share one chain so they stay mutually aligned: {sync, clk, x, y}
  logic [3:0]      sync_q [SYNC_STAGES];
  logic            clk_prev_q;

  logic [19:0]     sx_q, sx_d;
  logic [19:0]     sy_q, sy_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]     x_pos_q, x_pos_d;
  logic [15:0]     y_pos_q, y_pos_d;
  logic            x_valid_q, x_valid_d;
  logic            y_valid_q, y_valid_d;
  logic            x_err_q, x_err_d;
  logic            y_err_q, y_err_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            link_ok_q, link_ok_d;

  logic            s_sync, s_clk, s_x, s_y;
  logic            fall;
  logic [4:0]      cnt_inc;
  logic            len_ok, good_x, good_y, frame_good;

  always_comb begin
    s_sync     = sync_q[SYNC_STAGES-1][3];
    s_clk      = sync_q[SYNC_STAGES-1][2];
    s_x        = sync_q[SYNC_STAGES-1][1];
    s_y        = sync_q[SYNC_STAGES-1][0];
    fall       = clk_prev_q & ~s_clk;
    cnt_inc    = (bit_cnt_q == 5'd31) ? bit_cnt_q : bit_cnt_q + 5'd1;
    sx_d       = sx_q;
    sy_d       = sy_q;
    bit_cnt_d  = bit_cnt_q;
    x_pos_d    = x_pos_q;
    y_pos_d    = y_pos_q;
    x_valid_d  = 1'b0;
    y_valid_d  = 1'b0;
    x_err_d    = 1'b0;
    y_err_d    = 1'b0;
    err_cnt_d  = err_cnt_q;
    len_ok     = 1'b0;
    good_x     = 1'b0;
    good_y     = 1'b0;
    frame_good = 1'b0;
    if (fall) begin
      sx_d      = {sx_q[18:0], s_x};
      sy_d      = {sy_q[18:0], s_y};
      bit_cnt_d = cnt_inc;
      // Sync low on this edge marks the parity bit, i.e. the end of a frame
      if (!s_sync) begin
        len_ok     = (cnt_inc == 5'd20);
        good_x     = len_ok && (sx_d[19:17] == 3'b001) && !(^sx_d);
        good_y     = len_ok && (sy_d[19:17] == 3'b001) && !(^sy_d);
        frame_good = good_x && good_y;
        bit_cnt_d  = '0;
        if (good_x) begin
          x_pos_d   = sx_d[16:1];
          x_valid_d = 1'b1;
        end else begin
          x_err_d   = 1'b1;
        end
        if (good_y) begin
          y_pos_d   = sy_d[16:1];
          y_valid_d = 1'b1;
        end else begin
          y_err_d   = 1'b1;
        end
        if (!frame_good && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
      end
    end
    if (frame_good) begin
      wd_d = '0;
    end else if (wd_q == WD_MAX) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + 1'b1;
    end
    link_ok_d = (wd_q != WD_MAX);
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      clk_prev_q <= 1'b0;
      sx_q       <= '0;
      sy_q       <= '0;
      bit_cnt_q  <= '0;
      x_pos_q    <= '0;
      y_pos_q    <= '0;
      x_valid_q  <= 1'b0;
      y_valid_q  <= 1'b0;
      x_err_q    <= 1'b0;
      y_err_q    <= 1'b0;
      err_cnt_q  <= '0;
      wd_q       <= WD_MAX;
      link_ok_q  <= 1'b0;
    end else begin
      sync_q[0] <= {bus.xy_sync, bus.xy_clk, bus.xy_x, bus.xy_y};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      clk_prev_q <= s_clk;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      bit_cnt_q  <= bit_cnt_d;
      x_pos_q    <= x_pos_d;
      y_pos_q    <= y_pos_d;
      x_valid_q  <= x_valid_d;
      y_valid_q  <= y_valid_d;
      x_err_q    <= x_err_d;
      y_err_q    <= y_err_d;
      err_cnt_q  <= err_cnt_d;
      wd_q       <= wd_d;
      link_ok_q  <= link_ok_d;
    end
  end

  assign bus.x_pos   = x_pos_q;
  assign bus.y_pos   = y_pos_q;
  assign bus.x_valid = x_valid_q;
  assign bus.y_valid = y_valid_q;
  assign bus.x_err   = x_err_q;
  assign bus.y_err   = y_err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.link_ok = link_ok_q;

endmodule

// File: tb/tb_xy2_100_rx.sv
// Self-checking bench for xy2_100_rx: directed frames plus randomized frames
// checked against a frame-level model of the XY2-100 decoding rules.
module tb_xy2_100_rx;

  localparam int TO = 400;
  localparam int SS = 2;
  localparam int H  = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  xy2_100_rx_if bus ();

  xy2_100_rx #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut (
    .clk_in   (clk),
    .sys_rstn (rstn),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  int xv_n, yv_n, xe_n, ye_n, split_n;
  int last_good_cyc = -1;
  int rise_cyc = -1;
  int fall_cyc = -1;
  logic link_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.x_valid) xv_n++;
    if (bus.y_valid) yv_n++;
    if (bus.x_err)   xe_n++;
    if (bus.y_err)   ye_n++;
    if ((bus.x_valid | bus.x_err) != (bus.y_valid | bus.y_err)) split_n++;
    if (bus.x_valid && bus.y_valid) last_good_cyc = cyc;
    if (!link_prev && bus.link_ok) rise_cyc = cyc;
    if (link_prev && !bus.link_ok) fall_cyc = cyc;
    link_prev = bus.link_ok;
  end

  logic [15:0] exp_x, exp_y;
  int          exp_err;
  bit          exp_gx, exp_gy;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    xv_n = 0; yv_n = 0; xe_n = 0; ye_n = 0; split_n = 0;
  endtask

  function automatic logic [19:0] mk(input logic [2:0] c, input logic [15:0] d, input bit flip);
    logic [18:0] h;
    h = {c, d};
    return {h, (($countones(h) % 2) == 1) ^ flip};
  endfunction

  // Frame-level reference: only the last 20 bits matter and only a 20-bit frame can be good
  task automatic model_frame(input logic [31:0] xb, input logic [31:0] yb, input int n);
    exp_gx = (n == 20) && (xb[19:17] == 3'b001) && (($countones(xb[19:0]) % 2) == 0);
    exp_gy = (n == 20) && (yb[19:17] == 3'b001) && (($countones(yb[19:0]) % 2) == 0);
    if (exp_gx) exp_x = xb[16:1];
    if (exp_gy) exp_y = yb[16:1];
    if (!(exp_gx && exp_gy) && exp_err < 65535) exp_err++;
  endtask

  task automatic send_bits(input logic [31:0] xb, input logic [31:0] yb, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.xy_clk  = 1'b1;
      bus.xy_x    = xb[i];
      bus.xy_y    = yb[i];
      bus.xy_sync = (i != 0);
      wait_cyc(H);
      bus.xy_clk  = 1'b0;
      wait_cyc(H);
    end
  endtask

  task automatic do_frame(input logic [31:0] xb, input logic [31:0] yb, input int n);
    clear_mon();
    send_bits(xb, yb, n);
    wait_cyc(SS + 6);
    model_frame(xb, yb, n);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    wait_cyc(3);
    exp_x = '0; exp_y = '0; exp_err = 0;
    n_cmp++;
    if (bus.x_pos !== 16'h0 || bus.y_pos !== 16'h0) begin
      n_bad++; $display("FAIL reset_pos: got x=%h y=%h want 0000/0000", bus.x_pos, bus.y_pos);
    end
    n_cmp++;
    if ({bus.x_valid, bus.y_valid, bus.x_err, bus.y_err} !== 4'b0) begin
      n_bad++; $display("FAIL reset_pulses: got %b want 0000", {bus.x_valid, bus.y_valid, bus.x_err, bus.y_err});
    end
    n_cmp++;
    if (bus.err_cnt !== 16'h0 || bus.link_ok !== 1'b0) begin
      n_bad++; $display("FAIL reset_err_link: got err_cnt=%h link_ok=%b want 0000/0", bus.err_cnt, bus.link_ok);
    end
    rstn = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_good_frame();
    rise_cyc = -1;
    do_frame({12'h0, mk(3'b001, 16'h8000, 1'b0)}, {12'h0, mk(3'b001, 16'h1234, 1'b0)}, 20);
    n_cmp++;
    if (bus.x_pos !== 16'h8000 || bus.y_pos !== 16'h1234) begin
      n_bad++; $display("FAIL good_pos: got x=%h y=%h want 8000/1234", bus.x_pos, bus.y_pos);
    end
    n_cmp++;
    if (xv_n !== 1 || yv_n !== 1 || split_n !== 0 || xe_n !== 0 || ye_n !== 0) begin
      n_bad++; $display("FAIL good_pulses: got xv=%0d yv=%0d xe=%0d ye=%0d split=%0d want 1 1 0 0 0",
                        xv_n, yv_n, xe_n, ye_n, split_n);
    end
    n_cmp++;
    if (bus.err_cnt !== 16'h0) begin
      n_bad++; $display("FAIL good_errcnt: got %h want 0000", bus.err_cnt);
    end
    n_cmp++;
    if (rise_cyc - last_good_cyc !== 1) begin
      n_bad++; $display("FAIL good_link_rise: got %0d cycles after valid want 1", rise_cyc - last_good_cyc);
    end
  endtask

  task automatic test_parity_x();
    logic [15:0] dy;
    dy = 16'($urandom);
    do_frame({12'h0, mk(3'b001, 16'hFFFF, 1'b1)}, {12'h0, mk(3'b001, dy, 1'b0)}, 20);
    n_cmp++;
    if (xe_n !== 1 || yv_n !== 1 || xv_n !== 0 || ye_n !== 0) begin
      n_bad++; $display("FAIL parity_pulses: got xe=%0d yv=%0d xv=%0d ye=%0d want 1 1 0 0", xe_n, yv_n, xv_n, ye_n);
    end
    n_cmp++;
    if (bus.x_pos !== exp_x || bus.y_pos !== exp_y) begin
      n_bad++; $display("FAIL parity_pos: got x=%h y=%h want %h/%h", bus.x_pos, bus.y_pos, exp_x, exp_y);
    end
    n_cmp++;
    if (bus.err_cnt !== 16'(exp_err)) begin
      n_bad++; $display("FAIL parity_errcnt: got %0d want %0d", bus.err_cnt, exp_err);
    end
  endtask

  task automatic test_ctrl_x();
    do_frame({12'h0, mk(3'b000, 16'h5A5A, 1'b0)}, {12'h0, mk(3'b001, 16'h0F0F, 1'b0)}, 20);
    n_cmp++;
    if (xe_n !== 1 || bus.x_pos !== exp_x || bus.y_pos !== 16'h0F0F) begin
      n_bad++; $display("FAIL ctrl_x: got xe=%0d x=%h y=%h want 1 %h 0f0f", xe_n, bus.x_pos, bus.y_pos, exp_x);
    end
  endtask

  task automatic test_truncated();
    int e0;
    e0 = exp_err;
    do_frame(32'($urandom), 32'($urandom), 12);
    n_cmp++;
    if (xe_n !== 1 || ye_n !== 1 || bus.err_cnt !== 16'(e0 + 1)) begin
      n_bad++; $display("FAIL trunc_bad: got xe=%0d ye=%0d err_cnt=%0d want 1 1 %0d", xe_n, ye_n, bus.err_cnt, e0 + 1);
    end
    do_frame({12'h0, mk(3'b001, 16'h0001, 1'b0)}, {12'h0, mk(3'b001, 16'hBEEF, 1'b0)}, 20);
    n_cmp++;
    if (bus.x_pos !== 16'h0001 || bus.y_pos !== 16'hBEEF || xv_n !== 1) begin
      n_bad++; $display("FAIL trunc_recover: got x=%h y=%h xv=%0d want 0001 beef 1", bus.x_pos, bus.y_pos, xv_n);
    end
  endtask

  task automatic test_overlong();
    int e0;
    logic [31:0] xb, yb;
    e0 = exp_err;
    xb = {7'h0, 5'h15, mk(3'b001, 16'h7777, 1'b0)};
    yb = {7'h0, 5'h0A, mk(3'b001, 16'h2222, 1'b0)};
    do_frame(xb, yb, 25);
    n_cmp++;
    if (xe_n !== 1 || ye_n !== 1 || bus.err_cnt !== 16'(e0 + 1)) begin
      n_bad++; $display("FAIL overlong_bad: got xe=%0d ye=%0d err_cnt=%0d want 1 1 %0d", xe_n, ye_n, bus.err_cnt, e0 + 1);
    end
    do_frame({12'h0, mk(3'b001, 16'hC3A5, 1'b0)}, {12'h0, mk(3'b001, 16'h1111, 1'b0)}, 20);
    n_cmp++;
    if (bus.x_pos !== 16'hC3A5 || bus.y_pos !== 16'h1111) begin
      n_bad++; $display("FAIL overlong_recover: got x=%h y=%h want c3a5/1111", bus.x_pos, bus.y_pos);
    end
  endtask

  task automatic test_double_sync();
    do_frame(32'h1, 32'h0, 1);
    n_cmp++;
    if (xe_n !== 1 || ye_n !== 1 || bus.err_cnt !== 16'(exp_err) || bus.x_pos !== exp_x) begin
      n_bad++; $display("FAIL double_sync: got xe=%0d ye=%0d err_cnt=%0d x=%h want 1 1 %0d %h",
                        xe_n, ye_n, bus.err_cnt, bus.x_pos, exp_err, exp_x);
    end
  endtask

  task automatic test_random();
    logic [31:0] xb, yb;
    logic [2:0]  c;
    int n, kind;
    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 5);
      n  = 20;
      xb = {12'h0, mk(3'b001, 16'($urandom), 1'b0)};
      yb = {12'h0, mk(3'b001, 16'($urandom), 1'b0)};
      case (kind)
        1: xb = {12'h0, mk(3'b001, 16'($urandom), 1'b1)};
        2: yb = {12'h0, mk(3'b001, 16'($urandom), 1'b1)};
        3: begin
          c = 3'($urandom_range(0, 7));
          if (c == 3'b001) c = 3'b011;
          yb = {12'h0, mk(c, 16'($urandom), 1'b0)};
        end
        4: begin
          n = $urandom_range(1, 26);
          xb = (n > 20) ? ((32'($urandom) << 20) | xb) : 32'($urandom);
          yb = (n > 20) ? ((32'($urandom) << 20) | yb) : 32'($urandom);
        end
        default: ;
      endcase
      do_frame(xb, yb, n);
      n_cmp++;
      if (bus.x_pos !== exp_x || bus.y_pos !== exp_y || bus.err_cnt !== 16'(exp_err) ||
          xv_n !== int'(exp_gx) || xe_n !== int'(!exp_gx) ||
          yv_n !== int'(exp_gy) || ye_n !== int'(!exp_gy) || split_n !== 0) begin
        n_bad++;
        $display("FAIL random[%0d]: got x=%h y=%h err=%0d xv=%0d xe=%0d yv=%0d ye=%0d split=%0d want x=%h y=%h err=%0d gx=%0d gy=%0d (n=%0d)",
                 k, bus.x_pos, bus.y_pos, bus.err_cnt, xv_n, xe_n, yv_n, ye_n, split_n,
                 exp_x, exp_y, exp_err, exp_gx, exp_gy, n);
      end
    end
  endtask

  // Counter reaches TIMEOUT T cycles after the clearing update; the flag is registered one cycle later
  task automatic test_timeout();
    int budget;
    do_frame({12'h0, mk(3'b001, 16'h4242, 1'b0)}, {12'h0, mk(3'b001, 16'h2424, 1'b0)}, 20);
    fall_cyc = -1;
    n_cmp++;
    if (bus.link_ok !== 1'b1) begin
      n_bad++; $display("FAIL timeout_link_up: got %b want 1", bus.link_ok);
    end
    budget = 0;
    while (fall_cyc < 0 && budget < TO + 50) begin
      wait_cyc(1);
      budget++;
    end
    n_cmp++;
    if (fall_cyc - last_good_cyc !== TO + 1) begin
      n_bad++; $display("FAIL timeout_fall: got %0d cycles after update want %0d (fall_cyc=%0d)",
                        fall_cyc - last_good_cyc, TO + 1, fall_cyc);
    end
  endtask

  task automatic test_reset_midframe();
    logic [19:0] w;
    w = mk(3'b001, 16'h9999, 1'b0);
    for (int i = 19; i >= 10; i--) begin
      bus.xy_clk = 1'b1; bus.xy_x = w[i]; bus.xy_y = w[i]; bus.xy_sync = 1'b1;
      wait_cyc(H);
      bus.xy_clk = 1'b0;
      wait_cyc(H);
    end
    bus.xy_clk = 1'b1;
    wait_cyc(2);
    clear_mon();
    #2 rstn = 1'b0;
    #1;
    exp_x = '0; exp_y = '0; exp_err = 0;
    n_cmp++;
    if (bus.x_pos !== 16'h0 || bus.y_pos !== 16'h0 || bus.err_cnt !== 16'h0 || bus.link_ok !== 1'b0) begin
      n_bad++; $display("FAIL midreset_outputs: got x=%h y=%h err=%h link=%b want 0 0 0 0",
                        bus.x_pos, bus.y_pos, bus.err_cnt, bus.link_ok);
    end
    wait_cyc(4);
    rstn = 1'b1;
    bus.xy_clk = 1'b0;
    wait_cyc(20);
    n_cmp++;
    if (xv_n + yv_n + xe_n + ye_n !== 0) begin
      n_bad++; $display("FAIL midreset_pulses: got %0d pulses want 0", xv_n + yv_n + xe_n + ye_n);
    end
    do_frame({12'h0, mk(3'b001, 16'hABCD, 1'b0)}, {12'h0, mk(3'b001, 16'h0042, 1'b0)}, 20);
    n_cmp++;
    if (bus.x_pos !== 16'hABCD || bus.y_pos !== 16'h0042 || bus.err_cnt !== 16'h0) begin
      n_bad++; $display("FAIL midreset_after: got x=%h y=%h err=%h want abcd 0042 0000",
                        bus.x_pos, bus.y_pos, bus.err_cnt);
    end
  endtask

  initial begin
    bus.xy_clk  = 1'b0;
    bus.xy_sync = 1'b1;
    bus.xy_x    = 1'b0;
    bus.xy_y    = 1'b0;
    clear_mon();
    test_reset();
    test_good_frame();
    test_parity_x();
    test_ctrl_x();
    test_truncated();
    test_overlong();
    test_double_sync();
    test_random();
    test_timeout();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, got time %0t want < 2000000", $time);
    $fatal(1, "bench time limit reached");
  end

endmodule
